// File: rtl/afe2256_lvds_pkg.sv
// Shared types and constants for the AFE2256 LVDS transmit framer.
package afe2256_lvds_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_TRAIN = 2'd1,
        TX_DATA  = 2'd2
    } afe_tx_state_t;

    localparam logic [11:0] AFE_SYNC_HI      = 12'hFFF;
    localparam logic [11:0] AFE_SYNC_LO      = 12'h000;
    localparam int unsigned AFE_WORD_BITS    = 12;
    localparam int unsigned AFE_NIB_PER_WORD = 3;

    // Nibble sent in a given phase; MSB nibble leaves first.
    function automatic logic [3:0] afe_nibble(input logic [AFE_WORD_BITS-1:0] word,
                                              input logic [1:0] phase);
        case (phase)
            2'd0:    return word[11:8];
            2'd1:    return word[7:4];
            default: return word[3:0];
        endcase
    endfunction

endpackage

// File: rtl/afe2256_tx_testpat_gen.sv
// 12-bit ramp source for the framer's test-pattern mode (AFE2256_TX_TESTPAT_EN builds only).
module afe2256_tx_testpat_gen
    import afe2256_lvds_pkg::*;
(
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     adv,
    output logic [AFE_WORD_BITS-1:0] ramp
);

    logic [AFE_WORD_BITS-1:0] ramp_q, ramp_d;

    always_comb begin
        ramp_d = ramp_q;
        if (adv) begin
            ramp_d = ramp_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end

    assign ramp = ramp_q;

endmodule

// File: rtl/afe2256_lvds_tx_framer.sv
// AFE2256 LVDS transmit framer: IDLE/TRAIN/DATA word framing into DOUT/FCLK nibbles.
// Optional ramp test pattern enabled by macro AFE2256_TX_TESTPAT_EN.
module afe2256_lvds_tx_framer
    import afe2256_lvds_pkg::*;
#(
    parameter int unsigned              TRAIN_WORDS = 16,
    parameter logic [AFE_WORD_BITS-1:0] IDLE_WORD   = 12'h000
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     train_req,
`ifdef AFE2256_TX_TESTPAT_EN
    input  logic                     test_mode,
`endif
    input  logic [AFE_WORD_BITS-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [3:0]               dout_nib,
    output logic [3:0]               fclk_nib,
    output logic                     nib_valid,
    output logic [1:0]               tx_state,
    output logic [15:0]              word_cnt,
    output logic [7:0]               underrun_cnt
);

    localparam logic [8:0] TRAIN_LAST = 9'(2 * TRAIN_WORDS - 1);
    localparam logic [1:0] PH_LAST    = 2'(AFE_NIB_PER_WORD - 1);

    afe_tx_state_t            state_q, state_d;
    logic [1:0]               phase_q, phase_d;
    logic [AFE_WORD_BITS-1:0] word_q, word_d;
    logic [8:0]               train_cnt_q, train_cnt_d;
    logic                     pend_q, pend_d;
    logic [15:0]              word_cnt_q, word_cnt_d;
    logic [7:0]               underrun_q, underrun_d;
    logic [3:0]               dout_q, dout_d;
    logic [3:0]               fclk_q, fclk_d;
    logic                     nib_valid_q, nib_valid_d;

    logic                     boundary;
    logic                     train_hit;
    logic                     ready;
    logic                     load;
    logic                     tm;
    logic [AFE_WORD_BITS-1:0] ramp_word;

`ifdef AFE2256_TX_TESTPAT_EN
    assign tm = test_mode;

    afe2256_tx_testpat_gen u_testpat (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .adv     (load && tm),
        .ramp    (ramp_word)
    );
`else
    assign tm        = 1'b0;
    assign ramp_word = '0;
`endif

    assign boundary  = (state_q != TX_IDLE) && (phase_q == PH_LAST);
    // A train_req arriving on the boundary cycle itself is honoured immediately.
    assign train_hit = pend_q || train_req;
    assign ready     = (state_q == TX_DATA) && (phase_q == PH_LAST) && enable && !train_hit && !tm;
    // Boundary that starts a DATA word: end of training, or DATA continuing.
    assign load      = boundary && enable &&
                       (((state_q == TX_TRAIN) && (train_cnt_q == TRAIN_LAST)) ||
                        ((state_q == TX_DATA) && !train_hit));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        word_d      = word_q;
        train_cnt_d = train_cnt_q;
        pend_d      = pend_q;
        word_cnt_d  = word_cnt_q;
        underrun_d  = underrun_q;

        if ((state_q == TX_DATA) && train_req) begin
            pend_d = 1'b1;
        end
        if (state_q != TX_IDLE) begin
            phase_d = (phase_q == PH_LAST) ? 2'd0 : phase_q + 2'd1;
        end

        case (state_q)
            TX_IDLE: begin
                phase_d = '0;
                pend_d  = 1'b0;
                if (enable) begin
                    state_d     = TX_TRAIN;
                    word_d      = AFE_SYNC_HI;
                    train_cnt_d = '0;
                end
            end
            TX_TRAIN: begin
                if (boundary) begin
                    if (!enable) begin
                        state_d = TX_IDLE;
                    end else if (train_cnt_q == TRAIN_LAST) begin
                        state_d = TX_DATA;
                    end else begin
                        train_cnt_d = train_cnt_q + 9'd1;
                        word_d      = train_cnt_d[0] ? AFE_SYNC_LO : AFE_SYNC_HI;
                    end
                end
            end
            TX_DATA: begin
                if (boundary) begin
                    pend_d = 1'b0;
                    if (!enable) begin
                        state_d = TX_IDLE;
                    end else if (train_hit) begin
                        state_d     = TX_TRAIN;
                        train_cnt_d = '0;
                        word_d      = AFE_SYNC_HI;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        if (load) begin
            if (tm) begin
                word_d     = ramp_word;
                word_cnt_d = word_cnt_q + 16'd1;
            end else if (ready && s_valid) begin
                word_d     = s_data;
                word_cnt_d = word_cnt_q + 16'd1;
            end else begin
                word_d = IDLE_WORD;
                // The filler word on entry from TRAIN is not an underrun.
                if ((state_q == TX_DATA) && (underrun_q != 8'hFF)) begin
                    underrun_d = underrun_q + 8'd1;
                end
            end
        end

        if (state_d == TX_IDLE) begin
            word_d = '0;
        end

        nib_valid_d = (state_d != TX_IDLE);
        dout_d      = nib_valid_d ? afe_nibble(word_d, phase_d) : 4'h0;
        fclk_d      = (nib_valid_d && (phase_d == 2'd0)) ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            phase_q     <= '0;
            word_q      <= '0;
            train_cnt_q <= '0;
            pend_q      <= 1'b0;
            word_cnt_q  <= '0;
            underrun_q  <= '0;
            dout_q      <= '0;
            fclk_q      <= '0;
            nib_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            word_q      <= word_d;
            train_cnt_q <= train_cnt_d;
            pend_q      <= pend_d;
            word_cnt_q  <= word_cnt_d;
            underrun_q  <= underrun_d;
            dout_q      <= dout_d;
            fclk_q      <= fclk_d;
            nib_valid_q <= nib_valid_d;
        end
    end

    assign s_ready      = ready;
    assign dout_nib     = dout_q;
    assign fclk_nib     = fclk_q;
    assign nib_valid    = nib_valid_q;
    assign tx_state     = state_q;
    assign word_cnt     = word_cnt_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_afe2256_lvds_tx_framer.sv
// Scoreboard bench for afe2256_lvds_tx_framer (TRAIN_WORDS=2); ramp segment only with AFE2256_TX_TESTPAT_EN.
module tb_afe2256_lvds_tx_framer;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        train_req;
`ifdef AFE2256_TX_TESTPAT_EN
    logic        test_mode;
`endif
    logic [11:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  dout_nib;
    logic [3:0]  fclk_nib;
    logic        nib_valid;
    logic [1:0]  tx_state;
    logic [15:0] word_cnt;
    logic [7:0]  underrun_cnt;

    always #5 clk_sys = ~clk_sys;

    afe2256_lvds_tx_framer #(
        .TRAIN_WORDS (2),
        .IDLE_WORD   (12'h000)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .enable       (enable),
        .train_req    (train_req),
`ifdef AFE2256_TX_TESTPAT_EN
        .test_mode    (test_mode),
`endif
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .dout_nib     (dout_nib),
        .fclk_nib     (fclk_nib),
        .nib_valid    (nib_valid),
        .tx_state     (tx_state),
        .word_cnt     (word_cnt),
        .underrun_cnt (underrun_cnt)
    );

    logic [11:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    int          mon_ph  = 0;
    logic [11:0] mon_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [3:0] nib_of(input logic [11:0] w, input int ph);
        case (ph)
            0:       return w[11:8];
            1:       return w[7:4];
            default: return w[3:0];
        endcase
    endfunction

    task automatic push(input logic [11:0] w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(w);
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(negedge clk_sys);
            cyc++;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_state"}, tx_state, 2'd0);
        chk({tag, "_nib_valid"}, nib_valid, 1'b0);
        chk({tag, "_dout"}, dout_nib, 4'h0);
        chk({tag, "_fclk"}, fclk_nib, 4'h0);
        chk({tag, "_s_ready"}, s_ready, 1'b0);
    endtask

    // Monitor: pops one expected word per framed word and checks each nibble.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (nib_valid === 1'b1) begin
                if (mon_ph == 0) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_empty: framed nibble %h with no expected word (cycle %0d)", dout_nib, cyc);
                        mon_word = 12'hXXX;
                    end else begin
                        mon_word = exp_q.pop_front();
                    end
                end
                chk("sb_dout", dout_nib, nib_of(mon_word, mon_ph));
                chk("sb_fclk", fclk_nib, (mon_ph == 0) ? 4'hF : 4'h0);
                mon_ph = (mon_ph == 2) ? 0 : mon_ph + 1;
            end else begin
                mon_ph = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; train_req = 1'b0; s_valid = 1'b0; s_data = '0;
`ifdef AFE2256_TX_TESTPAT_EN
        test_mode = 1'b0;
`endif
        repeat (3) @(negedge clk_sys);
        chk_quiet("reset");
        chk("reset_word_cnt", word_cnt, 16'd0);
        chk("reset_underrun", underrun_cnt, 8'd0);

        // Training burst then DATA filler word.
        push(12'hFFF, 1); push(12'h000, 1); push(12'hFFF, 1); push(12'h000, 1);
        push(12'h000, 1);
        cyc = 0; rst_n = 1'b1; enable = 1'b1;
        step_to(1);
        chk("train_state", tx_state, 2'd1);
        chk("train_s_ready", s_ready, 1'b0);
        step_to(13);
        chk("data_entry_state", tx_state, 2'd2);
        chk("entry_no_underrun", underrun_cnt, 8'd0);
        s_valid = 1'b1; s_data = 12'hA5C;
        push(12'hA5C, 3);
        step_to(14); chk("s_ready_ph1", s_ready, 1'b0);
        step_to(15); chk("s_ready_ph2", s_ready, 1'b1);
        step_to(16); chk("word_cnt_1", word_cnt, 16'd1);
        step_to(22); chk("word_cnt_3", word_cnt, 16'd3);

        // Two underruns, then one accepted sample.
        s_valid = 1'b0;
        push(12'h000, 2); push(12'h3C7, 1);
        step_to(28);
        chk("underrun_2", underrun_cnt, 8'd2);
        s_valid = 1'b1; s_data = 12'h3C7;
        step_to(31);
        chk("word_cnt_4", word_cnt, 16'd4);
        s_valid = 1'b0;
        push(12'h000, 1);

        // train_req at phase 0: current word completes, then TRAIN.
        step_to(34);
        train_req = 1'b1;
        push(12'hFFF, 1); push(12'h000, 1); push(12'hFFF, 1); push(12'h000, 1);
        push(12'h000, 1);
        step_to(35); train_req = 1'b0;
        step_to(36); chk("s_ready_train_pending", s_ready, 1'b0);
        step_to(37);
        chk("train_after_req", tx_state, 2'd1);
        chk("underrun_3", underrun_cnt, 8'd3);
        step_to(40); train_req = 1'b1;
        step_to(41); train_req = 1'b0;
        step_to(49);
        chk("data_after_retrain", tx_state, 2'd2);
        push(12'h000, 1);
        step_to(52);
        chk("train_req_in_train_ignored", tx_state, 2'd2);
        chk("underrun_4", underrun_cnt, 8'd4);

        // Pending train and enable drop at the same boundary: IDLE wins.
        train_req = 1'b1;
        step_to(53); train_req = 1'b0;
        step_to(54);
        enable = 1'b0; s_valid = 1'b1; s_data = 12'h123;
        #1 chk("s_ready_enable_low", s_ready, 1'b0);
        step_to(55);
        chk_quiet("enable_drop");
        chk("enable_drop_word_cnt", word_cnt, 16'd4);
        chk("enable_drop_underrun", underrun_cnt, 8'd4);
        s_valid = 1'b0;
        push(12'hFFF, 1); push(12'h000, 1); push(12'hFFF, 1); push(12'h000, 1);
        push(12'h000, 2); push(12'h000, 260);
        step_to(56); enable = 1'b1;
        step_to(57); chk("retrain_from_idle", tx_state, 2'd1);
        step_to(72);
        chk("pending_cleared", tx_state, 2'd2);
        chk("underrun_5", underrun_cnt, 8'd5);

        // Long underrun run saturates the counter.
        step_to(852);
        chk("underrun_saturated", underrun_cnt, 8'd255);
        chk("word_cnt_held", word_cnt, 16'd4);

        // Reset at phase 1 truncates the word.
        step_to(853); rst_n = 1'b0; enable = 1'b0;
        step_to(854);
        chk_quiet("midword_reset");
        chk("midword_reset_word_cnt", word_cnt, 16'd0);
        chk("midword_reset_underrun", underrun_cnt, 8'd0);

`ifdef AFE2256_TX_TESTPAT_EN
        step_to(856);
        rst_n = 1'b1; enable = 1'b1; test_mode = 1'b1;
        push(12'hFFF, 1); push(12'h000, 1); push(12'hFFF, 1); push(12'h000, 1);
        push(12'h000, 1); push(12'h001, 1); push(12'h002, 1);
        step_to(871); chk("testpat_s_ready", s_ready, 1'b0);
        step_to(877); enable = 1'b0;
        step_to(878);
        chk("testpat_word_cnt", word_cnt, 16'd3);
        chk("testpat_idle", tx_state, 2'd0);
`endif

        step_to(cyc + 3);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
